// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the memory arbiter.
// Load-store length encoding is shared with the requesters' LSU.
package mem_arbiter_pkg;

    // Transfer size, same encoding the load-store unit drives
    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2
    } ls_len_e;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    // Owner encoding: one bit, DMA = 1 so it lines up with grant[1]
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // Width of the memory-wait counter
    localparam int TMO_W = 16;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational two-way round-robin picker.
// grant[0] = CPU, grant[1] = DMA; on a tie the side not served last wins.
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic       i_cpu_req,
    input  logic       i_dma_req,
    input  logic       i_last_owner,
    output logic [1:0] o_grant
);

    // Pick one requester; a lone requester wins regardless of history
    always_comb begin
        o_grant = 2'b00;
        if (i_cpu_req && i_dma_req)
            o_grant = (i_last_owner == OWNER_DMA) ? 2'b01 : 2'b10;
        else if (i_cpu_req)
            o_grant = 2'b01;
        else if (i_dma_req)
            o_grant = 2'b10;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/DMA arbiter onto a single memory port (IDLE/BUSY/ACK).
// Optional memory-wait timeout: define MEM_ARBITER_TIMEOUT_EN. Without it
// BUSY waits indefinitely and the err outputs are tied low.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_len,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [1:0]  dma_len,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,

    output logic        mem_valid,
    output logic        mem_we,
    output logic [1:0]  mem_len,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    arb_state_e  r_state;
    arb_state_e  w_next_state;
    logic        r_owner;
    logic        r_last_owner;
    logic [1:0]  w_grant;
    logic        w_sel_dma;
    logic        w_done;
    logic        w_tmo;
    logic        w_cpu_ack;
    logic        w_dma_ack;
    logic [31:0] w_rdata_cap;

    logic        r_mem_valid;
    logic        r_mem_we;
    logic [1:0]  r_mem_len;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dma_rdata;

    mem_arb_rr u_rr (
        .i_cpu_req    (cpu_req),
        .i_dma_req    (dma_req),
        .i_last_owner (r_last_owner),
        .o_grant      (w_grant)
    );

    assign w_sel_dma = w_grant[1];

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_cpu_err;
    logic             r_dma_err;

    // Count BUSY cycles; zero whenever not waiting on memory
    always_ff @(posedge clk) begin
        if (reset || r_state != ST_BUSY)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    // A ready in the expiry cycle still counts as a normal completion
    assign w_tmo = (r_state == ST_BUSY) && !mem_ready && (r_tmo_cnt == TMO_LAST);

    // Per-requester timeout flag, written at completion, held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_err <= 1'b0;
            r_dma_err <= 1'b0;
        end else if (w_done) begin
            if (r_owner == OWNER_DMA) r_dma_err <= w_tmo;
            else                      r_cpu_err <= w_tmo;
        end
    end

    assign cpu_err = r_cpu_err;
    assign dma_err = r_dma_err;
`else
    assign w_tmo   = 1'b0;
    assign cpu_err = 1'b0;
    assign dma_err = 1'b0;
`endif

    // Memory phase ends on ready or on timeout; ready outside BUSY is ignored
    assign w_done      = (r_state == ST_BUSY) && (mem_ready || w_tmo);
    assign w_rdata_cap = (r_mem_we || w_tmo) ? 32'd0 : mem_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next state and the one-cycle ack pulse to the current owner
    always_comb begin
        w_next_state = r_state;
        w_cpu_ack    = 1'b0;
        w_dma_ack    = 1'b0;
        case (r_state)
            ST_IDLE: if (|w_grant) w_next_state = ST_BUSY;
            ST_BUSY: if (w_done)   w_next_state = ST_ACK;
            ST_ACK: begin
                w_next_state = ST_IDLE;
                w_cpu_ack    = (r_owner == OWNER_CPU);
                w_dma_ack    = (r_owner == OWNER_DMA);
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Grant latches owner and fields; completion captures read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= OWNER_CPU;
            r_last_owner <= OWNER_DMA;   // CPU wins the first tie
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_len    <= LEN_WORD;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            if (r_state == ST_IDLE && |w_grant) begin
                r_owner      <= w_sel_dma;
                r_last_owner <= w_sel_dma;
                r_mem_valid  <= 1'b1;
                r_mem_we     <= w_sel_dma ? dma_we    : cpu_we;
                r_mem_len    <= w_sel_dma ? dma_len   : cpu_len;
                r_mem_addr   <= w_sel_dma ? dma_addr  : cpu_addr;
                r_mem_wdata  <= w_sel_dma ? dma_wdata : cpu_wdata;
            end
            if (w_done) begin
                r_mem_valid <= 1'b0;
                if (r_owner == OWNER_DMA) r_dma_rdata <= w_rdata_cap;
                else                      r_cpu_rdata <= w_rdata_cap;
            end
        end
    end

    assign cpu_ack   = w_cpu_ack;
    assign dma_ack   = w_dma_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_len   = r_mem_len;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the memory-wait limit in cycles (range 1..65535).
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 {cpu,dma}_req  input  1  requester wants a transfer; held with its fields until its ack.
REQ-005 {cpu,dma}_we  input  1  1 = write, 0 = read.
REQ-006 {cpu,dma}_len  input  2  byte/half/word size, shared load-store encoding.
REQ-007 {cpu,dma}_addr  input  32  byte address.
REQ-008 {cpu,dma}_wdata  input  32  write data.
REQ-009 {cpu,dma}_ack  output  1  one-cycle completion pulse to owner.
REQ-010 {cpu,dma}_rdata  output  32  read data, valid in the ack cycle.
REQ-011 {cpu,dma}_err  output  1  timeout flag, valid in the ack cycle.
REQ-012 mem_valid  output  1  transfer request to the single memory port.
REQ-013 mem_we, mem_len, mem_addr, mem_wdata  output  1/2/32/32  registered copy of the owner's fields.
REQ-014 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-015 mem_ready  input  1  memory completes the transfer this cycle.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and ACK.
REQ-017 In IDLE, with any req high: latch owner and fields, assert mem_valid next cycle, go to BUSY.
REQ-018 Tie (both req in the same IDLE cycle): grant the requester not served last (round-robin); last_owner updates at grant.
REQ-019 Single requester: grant it regardless of last_owner.
REQ-020 In BUSY, mem_valid and mem_* SHALL stay constant until mem_ready is sampled high.
REQ-021 On mem_ready: drop mem_valid, capture mem_rdata, go to ACK.
REQ-022 In ACK: pulse the owner's ack for exactly one cycle, with rdata (0 for writes) and err, then go to IDLE.
REQ-023 The non-owner's ack SHALL stay 0; its rdata and err SHALL hold their last values.
REQ-024 Latency: req in IDLE at cycle 0 -> mem_valid at cycle 1; mem_ready at cycle k -> ack at cycle k+1; minimum 3 cycles req->ack.
REQ-025 Back-to-back: arbitration resumes in the IDLE cycle after ACK; a still-pending other requester SHALL be granted next.
REQ-026 An owner dropping req mid-transfer SHALL NOT abort it; ack is still issued.
REQ-027 mem_ready outside BUSY SHALL be ignored.

Reset
REQ-028 Reset SHALL force: state IDLE; mem_valid, mem_we, all acks, all errs = 0; mem_addr, mem_wdata, rdata = 0; mem_len = word; last_owner = DMA, so the CPU wins the first tie.
REQ-029 Reset asserted in BUSY or ACK SHALL abandon the transfer with no ack; the timeout counter is cleared.

Configuration
REQ-030 Macro MEM_ARBITER_TIMEOUT_EN, when defined: a 16-bit counter runs in BUSY; if mem_ready is not seen after TIMEOUT_CYCLES cycles, drop mem_valid and go to ACK with err = 1 and rdata = 0.
REQ-031 mem_ready in the same cycle as expiry SHALL win (normal completion, err = 0).
REQ-032 Macro undefined: no counter is present, err outputs are constant 0, and BUSY waits indefinitely.

Structure
REQ-033 Shared package SHALL hold the load-store length encodings (byte/half/word) and the arbiter state encoding.
REQ-034 The round-robin picker SHALL be one sub-module, mem_arb_rr, which is combinational: inputs 2 reqs and last_owner; output grant one-hot.

Verification
REQ-035 Test 1: CPU read only, addr 0x100, mem_ready 2 cycles after mem_valid -> mem_addr = 0x100 at cycle 1; cpu_ack at cycle 4 with cpu_rdata = mem_rdata (0xDEADBEEF).
REQ-036 Test 2: both req in the first cycle after reset -> CPU granted first; DMA granted in the IDLE cycle after cpu_ack; dma_ack never overlaps cpu_ack.
REQ-037 Test 3: both requesting continuously for 10 transfers -> grants alternate CPU, DMA, CPU, DMA...; each side gets 5.
REQ-038 Test 4: DMA byte write, addr 0x3, wdata 0xAB, len byte -> mem_we = 1 and mem_len = byte held stable until mem_ready; dma_rdata = 0.
REQ-039 Test 5: reset pulsed in BUSY -> mem_valid = 0 on the next cycle; no ack; the next CPU request is served normally.
REQ-040 Test 6 (TIMEOUT_EN, TIMEOUT_CYCLES = 8): mem_ready held low -> mem_valid dropped after 8 BUSY cycles; cpu_ack with cpu_err = 1; mem_ready on the 8th cycle -> err = 0.
